// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: valid/ready word channel between the UART receiver and its consumer
//   rx_data  : received word, stable while rx_valid is high
//   rx_valid : word available (driven by the receiver)
//   rx_ready : consumer accepts (driven by the consumer)
//   master modport = receiver side, slave modport = consumer side
`timescale 1ns/1ps
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master(output rx_data, output rx_valid, input rx_ready);
  modport slave(input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (data width, parity, stop bits) with valid/ready output
//   clk, rst_n  : clock, asynchronous active-low reset
//   RX_data     : asynchronous serial line, idle high
//   rx          : uart_rx_param_if.master (rx_data, rx_valid out; rx_ready in)
//   frame_err, parity_err, break_det, overrun_err : one-cycle status pulses
//   busy        : receiver not idle
//   Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the mid-bit point.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLOCK_PER_BIT = 20,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  input logic RX_data,
  uart_rx_param_if.master rx,
  output logic frame_err,
  output logic parity_err,
  output logic break_det,
  output logic overrun_err,
  output logic busy
);
  localparam int CW = $clog2(CLOCK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M = (CLOCK_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SM = M + 1;
`else
  localparam int SM = M;
`endif
  localparam logic [CW-1:0] START_END = CW'(SM);
  localparam logic [CW-1:0] BIT_END = CW'(CLOCK_PER_BIT - 1);
  localparam logic ODD = (PARITY_MODE == 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH} state_t;
  state_t state, nxt;
  logic s_meta, s, b, tick, last_data, last_stop, done, good;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic zero, par_bad, stop_bad, stop_cnt;
`ifdef UART_RX_MAJORITY_EN
  // h[0] is s one cycle ago, h[1] two cycles ago: a decision at M+1 votes on M-1, M, M+1
  logic [1:0] h;
  assign b = (h[1] & h[0]) | (h[1] & s) | (h[0] & s);
`else
  assign b = s;
`endif
  // Data-phase bits are timed from the previous decision, so every later bit lands mid-bit too
  assign tick = (state == START) ? cnt == START_END : cnt == BIT_END;
  assign last_data = idx == IW'(DATA_BITS - 1);
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  assign done = state == DONE;
  assign good = done & ~zero & ~stop_bad & ~par_bad;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = s ? IDLE : START;
      START: nxt = tick ? (b ? IDLE : DATA) : START;
      DATA: nxt = (tick && last_data) ? ((PARITY_MODE != 0) ? PARITY : STOP) : DATA;
      PARITY: nxt = tick ? STOP : PARITY;
      STOP: nxt = (tick && last_stop) ? DONE : STOP;
      DONE: nxt = s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: nxt = s ? IDLE : WAIT_HIGH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      s <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      h <= 2'b11;
`endif
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      zero <= 1'b0;
      par_bad <= 1'b0;
      stop_bad <= 1'b0;
      stop_cnt <= 1'b0;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      break_det <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      s_meta <= RX_data;
      s <= s_meta;
`ifdef UART_RX_MAJORITY_EN
      h <= {h[0], s};
`endif
      state <= nxt;
      cnt <= (tick || state == IDLE || state == DONE || state == WAIT_HIGH) ? '0 : cnt + 1'b1;
      if (tick && state == START) begin
        idx <= '0;
        zero <= 1'b1;
        par_bad <= 1'b0;
        stop_bad <= 1'b0;
        stop_cnt <= 1'b0;
      end
      if (tick && state == DATA) begin
        shreg <= {b, shreg[DATA_BITS-1:1]};
        idx <= idx + 1'b1;
        zero <= zero & ~b;
      end
      if (tick && state == PARITY) begin
        par_bad <= b != (^shreg ^ ODD);
        zero <= zero & ~b;
      end
      if (tick && state == STOP) begin
        stop_bad <= stop_bad | ~b;
        stop_cnt <= ~stop_cnt;
        zero <= zero & ~b;
      end
      // A break masks the framing error its low stop bits would otherwise raise
      break_det <= done & zero;
      frame_err <= done & ~zero & stop_bad;
      parity_err <= done & ~zero & ~stop_bad & par_bad;
      overrun_err <= good & rx.rx_valid & ~rx.rx_ready;
      // A handshake in the same cycle frees the register, so the new word can load without overrun
      if (good && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end
endmodule
